act_buffer_loader: RTL

- Write-side producer for the ping-pong activation buffer.
- Accepts a byte-packed activation stream from DMA (valid/ready/last) and repacks it into TM-byte rows.
- Drives the buffer write port (we/waddr/wdata/bank_sel_wr) and owns bank ownership tracking.
- Hands completed banks to the systolic-array side through bank_sel_rd/rd_bank_valid/bank_release.

---
 rtl/act_buffer_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/act_buffer_loader.sv
// act_buffer_loader: repacks a byte stream into TM-byte rows of a ping-pong activation buffer
// Ports: clk/rst (async, active-high); start/tile_rows/busy tile control;
// s_valid/s_ready/s_data/s_last input stream; we/waddr/wdata/bank_sel_wr buffer write port;
// bank_sel_rd/rd_bank_valid/bank_release consumer handoff; tile_done/tile_short/tile_overrun/rows_written status.
module act_buffer_loader #(
  parameter int TM = 14,
  parameter int ADDR_WIDTH = 7,
  parameter int IN_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     tile_rows,
  output logic                    busy,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_BYTES*8-1:0]   s_data,
  input  logic                    s_last,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   waddr,
  output logic [TM*8-1:0]         wdata,
  output logic                    bank_sel_wr,
  output logic                    bank_sel_rd,
  output logic                    rd_bank_valid,
  input  logic                    bank_release,
  output logic                    tile_done,
  output logic                    tile_short,
  output logic                    tile_overrun,
  output logic [ADDR_WIDTH:0]     rows_written
);
  localparam int PB = TM + IN_BYTES - 1;
  localparam int CW = $clog2(PB + 1);
  localparam logic [CW-1:0] TMC = CW'(TM);
  localparam logic [CW-1:0] INC = CW'(IN_BYTES);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  typedef enum logic [2:0] {IDLE, WAIT_BANK, FILL, FLUSH, DRAIN, DONE} state_t;
  state_t state, ns;
  logic [PB*8-1:0] pk, pk_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_WIDTH:0] rows, rows_n, rw_n;
  logic lst, lst_n, ovr_n, we_n, wr_n, rd_n, rel, acc;
  logic [1:0] full, full_n;
  logic [ADDR_WIDTH-1:0] waddr_n;
  logic [TM*8-1:0] wdata_n;
  assign acc = s_valid & s_ready;
  assign rel = bank_release & rd_bank_valid;
  // Packer bytes above cnt are kept zero, so appends can OR in place and the
  // flush row comes out zero-padded without masking.
  always_comb begin
    ns = state;
    pk_n = pk;
    cnt_n = cnt;
    rows_n = rows;
    rw_n = rows_written;
    lst_n = lst;
    ovr_n = 1'b0;
    we_n = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;
    full_n = full;
    wr_n = bank_sel_wr;
    rd_n = bank_sel_rd;
    case (state)
      IDLE: if (start && tile_rows != '0) begin
        rows_n = tile_rows;
        rw_n = '0;
        lst_n = 1'b0;
        ns = WAIT_BANK;
      end
      WAIT_BANK: ns = full[bank_sel_wr] ? WAIT_BANK : FILL;
      FILL: if (rows_written == rows) ns = lst ? DONE : DRAIN;
      else if (cnt >= TMC) begin
        we_n = 1'b1;
        waddr_n = rows_written[ADDR_WIDTH-1:0];
        wdata_n = pk[TM*8-1:0];
        pk_n = pk >> (8*TM);
        cnt_n = cnt - TMC;
        rw_n = rows_written + ONE;
      end
      else if (lst) ns = (cnt != '0) ? FLUSH : DONE;
      else if (acc) begin
        pk_n = pk | ((PB*8)'(s_data) << {cnt, 3'b000});
        cnt_n = cnt + INC;
        lst_n = s_last;
      end
      FLUSH: begin
        we_n = 1'b1;
        waddr_n = rows_written[ADDR_WIDTH-1:0];
        wdata_n = pk[TM*8-1:0];
        rw_n = rows_written + ONE;
        ns = DONE;
      end
      DRAIN: if (acc && s_last) begin
        ns = DONE;
        ovr_n = 1'b1;
      end
      DONE: begin
        full_n[bank_sel_wr] = 1'b1;
        wr_n = ~bank_sel_wr;
        pk_n = '0;
        cnt_n = '0;
        ns = IDLE;
      end
      default: ns = IDLE;
    endcase
    if (rel) begin
      full_n[bank_sel_rd] = 1'b0;
      rd_n = ~bank_sel_rd;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pk <= '0;
      cnt <= '0;
      rows <= '0;
      rows_written <= '0;
      lst <= 1'b0;
      full <= 2'b00;
      bank_sel_wr <= 1'b0;
      bank_sel_rd <= 1'b0;
      rd_bank_valid <= 1'b0;
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      busy <= 1'b0;
      tile_done <= 1'b0;
      tile_short <= 1'b0;
      tile_overrun <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      state <= ns;
      pk <= pk_n;
      cnt <= cnt_n;
      rows <= rows_n;
      rows_written <= rw_n;
      lst <= lst_n;
      full <= full_n;
      bank_sel_wr <= wr_n;
      bank_sel_rd <= rd_n;
      rd_bank_valid <= full_n[rd_n];
      we <= we_n;
      waddr <= waddr_n;
      wdata <= wdata_n;
      busy <= ns != IDLE;
      tile_done <= ns == DONE;
      tile_short <= ns == DONE && rw_n < rows_n;
      tile_overrun <= ns == DONE && ovr_n;
      // Registered ready: asserted only for cycles in which the FSM will take a beat.
      s_ready <= ns == DRAIN || (ns == FILL && cnt_n < TMC && !lst_n && rw_n != rows_n);
    end
endmodule
